// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller.
//   SLICE_W    : width of the shared adder slice (one nibble)
//   state_t    : controller states IDLE / RUN / DONE
//   signed_ovf : two's-complement overflow from the operand and result sign bits
package serial_add_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Overflow occurs when both addends share a sign and the result sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fast_adder4.sv
// 4-bit carry-lookahead adder slice, reused once per nibble by the controller.
// Ports:
//   a, b  : 4-bit addends
//   c_in  : carry into bit 0
//   sum   : 4-bit sum
//   c_out : carry out of bit 3
module fast_adder4
    import serial_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c_in,
    output logic [SLICE_W-1:0] sum,
    output logic               c_out
);

    logic [SLICE_W-1:0] gen_s;
    logic [SLICE_W-1:0] prop_s;
    logic [SLICE_W:0]   carry_s;

    // Generate/propagate terms and fully expanded lookahead carries.
    always_comb begin
        gen_s      = a & b;
        prop_s     = a ^ b;
        carry_s[0] = c_in;
        carry_s[1] = gen_s[0] | (prop_s[0] & c_in);
        carry_s[2] = gen_s[1] | (prop_s[1] & gen_s[0]) | (prop_s[1] & prop_s[0] & c_in);
        carry_s[3] = gen_s[2] | (prop_s[2] & gen_s[1]) | (prop_s[2] & prop_s[1] & gen_s[0])
                   | (prop_s[2] & prop_s[1] & prop_s[0] & c_in);
        carry_s[4] = gen_s[3] | (prop_s[3] & gen_s[2]) | (prop_s[3] & prop_s[2] & gen_s[1])
                   | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0])
                   | (prop_s[3] & prop_s[2] & prop_s[1] & prop_s[0] & c_in);
        sum        = prop_s ^ carry_s[SLICE_W-1:0];
        c_out      = carry_s[SLICE_W];
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder/subtractor with valid/ready handshakes on both sides.
// One operation is accepted in IDLE, processed one nibble per cycle (LSB
// first) through a single shared 4-bit lookahead slice in RUN, and held in
// DONE until the consumer takes it.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operation handshake (ready only in IDLE)
//   a, b, sub           : operands, sub=1 selects a-b
//   out_valid/out_ready : result handshake (valid only in DONE)
//   result, c_out, ovf  : sum/difference, final carry (1 = no borrow), signed overflow
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*NIBBLES-1:0] a,
    input  logic [SLICE_W*NIBBLES-1:0] b,
    input  logic                       sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*NIBBLES-1:0] result,
    output logic                       c_out,
    output logic                       ovf
);

    localparam int W     = SLICE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state_r;
    state_t             state_next_s;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [W-1:0]       result_r;
    logic               c_out_r;
    logic               ovf_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [SLICE_W-1:0] a_slice_s;
    logic [SLICE_W-1:0] b_slice_s;
    logic [SLICE_W-1:0] sum_s;
    logic               slice_c_out_s;
    logic               last_idx_s;

    // Select the current nibble of each latched operand.
    always_comb begin
        a_slice_s  = a_r[idx_r*SLICE_W +: SLICE_W];
        b_slice_s  = b_r[idx_r*SLICE_W +: SLICE_W];
        last_idx_s = (idx_r == IDX_W'(NIBBLES - 1));
    end

    fast_adder4 u_slice (
        .a     (a_slice_s),
        .b     (b_slice_s),
        .c_in  (carry_r),
        .sum   (sum_s),
        .c_out (slice_c_out_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_idx_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they track state_r exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture and serial datapath; subtraction is a + ~b + 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            idx_r    <= '0;
            result_r <= '0;
            c_out_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b ^ {W{sub}};
                        carry_r <= sub;
                        idx_r   <= '0;
                    end else begin
                        carry_r <= carry_r;
                    end
                end
                ST_RUN: begin
                    result_r[idx_r*SLICE_W +: SLICE_W] <= sum_s;
                    carry_r <= slice_c_out_s;
                    if (last_idx_s) begin
                        c_out_r <= slice_c_out_s;
                        // sum_s[3] is the result MSB on the final nibble.
                        ovf_r   <= signed_ovf(a_r[W-1], b_r[W-1], sum_s[SLICE_W-1]);
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    carry_r <= carry_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign c_out     = c_out_r;
    assign ovf       = ovf_r;

endmodule
